// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Widest requester vector the index helper accepts.
  localparam int MAX_REQ = 64;

  function automatic int arbIdw(input int nReq);
    return (nReq < 2) ? 1 : $clog2(nReq);
  endfunction

  function automatic int arbCntw(input int maxBurst);
    return $clog2(maxBurst + 1);
  endfunction

  // OR-encoding is exact for a one-hot input and returns 0 for all-zero.
  function automatic int unsigned oneHotToIdx(input logic [MAX_REQ-1:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (vec[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set bit of req at or above ptr, with wrap.
module rr_pick
  import arb_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int IDW   = arbIdw(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] winner,
  output logic             found
);

  logic [N_REQ-1:0] rot;
  logic [N_REQ-1:0] rotWin;

  // Rotate so that bit 0 of rot is requester ptr.
  assign rot = N_REQ'({req, req} >> ptr);

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_prio
      if (gi == 0) begin : g_first
        assign rotWin[gi] = rot[gi];
      end else begin : g_rest
        assign rotWin[gi] = rot[gi] & ~(|rot[gi-1:0]);
      end
    end
  endgenerate

  assign winner = N_REQ'(({rotWin, rotWin} << ptr) >> N_REQ);
  assign found  = |req;

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter granting one requester at a time in bursts of at most MAX_BURST cycles.
module rr_burst_arbiter
  import arb_pkg::*;
#(
  parameter  int N_REQ     = 2,
  parameter  int MAX_BURST = 4,
  localparam int IDW       = arbIdw(N_REQ),
  localparam int CNTW      = arbCntw(MAX_BURST)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] last,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [IDW-1:0]   gnt_id,
  output logic [CNTW-1:0]  burst_cnt
);

  arb_state_e       state, stateNext;
  logic [IDW-1:0]   ptr, ptrNext;
  logic [IDW-1:0]   own, ownNext;
  logic [IDW-1:0]   ownPlus1;
  logic [IDW-1:0]   searchPtr;
  logic [IDW-1:0]   winIdx;
  logic [N_REQ-1:0] gntNext;
  logic [N_REQ-1:0] winner;
  logic [CNTW-1:0]  cnt, cntNext;
  logic             found;
  logic             rel;

  assign ownPlus1 = (own == IDW'(N_REQ - 1)) ? '0 : own + IDW'(1);
  // On release the search starts just past the owner, so the owner only wins again when alone.
  assign searchPtr = (state == GRANT) ? ownPlus1 : ptr;
  assign rel = ~req[own] | last[own] | (cnt == CNTW'(MAX_BURST));
  assign winIdx = IDW'(oneHotToIdx(MAX_REQ'(winner)));

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req   (req),
    .ptr   (searchPtr),
    .winner(winner),
    .found (found)
  );

  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    ownNext   = own;
    gntNext   = gnt;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (found) begin
          stateNext = GRANT;
          ownNext   = winIdx;
          gntNext   = winner;
          cntNext   = CNTW'(1);
        end
      end
      GRANT: begin
        if (!rel) begin
          cntNext = cnt + CNTW'(1);
        end else begin
          ptrNext = ownPlus1;
          if (found) begin
            ownNext = winIdx;
            gntNext = winner;
            cntNext = CNTW'(1);
          end else begin
            stateNext = IDLE;
            gntNext   = '0;
            cntNext   = '0;
          end
        end
      end
      default: begin
        stateNext = IDLE;
        gntNext   = '0;
        cntNext   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      own   <= '0;
      gnt   <= '0;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      ptr   <= ptrNext;
      own   <= ownNext;
      gnt   <= gntNext;
      cnt   <= cntNext;
    end
  end

  assign gnt_valid = |gnt;
  assign gnt_id    = own;
  assign burst_cnt = cnt;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Randomized and directed bench for rr_burst_arbiter against a behavioural model (2x4 and 3x1 instances).
module tb_rr_burst_arbiter;

  localparam int NA  = 2;
  localparam int MBA = 4;
  localparam int NB  = 3;
  localparam int MBB = 1;
  localparam int BOUND_A = (NA - 1) * MBA + 1;
  localparam int BOUND_B = (NB - 1) * MBB + 1;

  logic clk = 1'b0;
  logic reset;

  logic [NA-1:0] reqA, lastA, gntA;
  logic          validA;
  logic [0:0]    idA;
  logic [2:0]    cntA;

  logic [NB-1:0] reqB, lastB, gntB;
  logic          validB;
  logic [1:0]    idB;
  logic [0:0]    cntB;

  always #5 clk = ~clk;

  rr_burst_arbiter #(.N_REQ(NA), .MAX_BURST(MBA)) dutA (
    .clk(clk), .reset(reset), .req(reqA), .last(lastA),
    .gnt(gntA), .gnt_valid(validA), .gnt_id(idA), .burst_cnt(cntA)
  );

  rr_burst_arbiter #(.N_REQ(NB), .MAX_BURST(MBB)) dutB (
    .clk(clk), .reset(reset), .req(reqB), .last(lastB),
    .gnt(gntB), .gnt_valid(validB), .gnt_id(idB), .burst_cnt(cntB)
  );

  int checks = 0;
  int failures = 0;
  int tickNo = 0;

  // Behavioural model state per instance: 0 = A, 1 = B.
  int mOwn[2];
  int mCnt[2];
  int mPtr[2];
  bit mValid[2];

  int waitA[NA];
  int waitB[NB];
  int maxWaitA = 0;
  int maxWaitB = 0;

  always @(negedge clk) begin
    if (!reset) begin
      assert ($onehot0(gntA) && $onehot0(gntB)) else $error("grant vector not one-hot");
    end
  end

  task automatic checkEq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d (tick %0d)", tag, obs, exp, tickNo);
    end
  endtask

  function automatic int pickFrom(input int n, input int reqv, input int start);
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = (start + k) % n;
      if (((reqv >> idx) & 1) == 1) return idx;
    end
    return -1;
  endfunction

  task automatic modelStep(input int k, input int n, input int mb, input int reqv,
                           input int lastv, input bit rst);
    int w;
    bit rel;
    if (rst) begin
      mValid[k] = 0; mOwn[k] = 0; mCnt[k] = 0; mPtr[k] = 0;
    end else if (!mValid[k]) begin
      w = pickFrom(n, reqv, mPtr[k]);
      if (w >= 0) begin
        mValid[k] = 1; mOwn[k] = w; mCnt[k] = 1;
      end
    end else begin
      rel = (((reqv >> mOwn[k]) & 1) == 0) || (((lastv >> mOwn[k]) & 1) == 1) || (mCnt[k] == mb);
      if (!rel) begin
        mCnt[k] = mCnt[k] + 1;
      end else begin
        mPtr[k] = (mOwn[k] + 1) % n;
        w = pickFrom(n, reqv, mPtr[k]);
        if (w >= 0) begin
          mOwn[k] = w; mCnt[k] = 1;
        end else begin
          mValid[k] = 0; mCnt[k] = 0;
        end
      end
    end
  endtask

  function automatic int expGnt(input int k);
    return mValid[k] ? (1 << mOwn[k]) : 0;
  endfunction

  task automatic tick(input bit rst, input logic [NA-1:0] ra, input logic [NA-1:0] la,
                      input logic [NB-1:0] rb, input logic [NB-1:0] lb);
    reset = rst; reqA = ra; lastA = la; reqB = rb; lastB = lb;
    for (int i = 0; i < NA; i++) begin
      if (rst || !ra[i] || gntA[i]) waitA[i] = 0;
      else waitA[i] = waitA[i] + 1;
      if (waitA[i] > maxWaitA) maxWaitA = waitA[i];
    end
    for (int i = 0; i < NB; i++) begin
      if (rst || !rb[i] || gntB[i]) waitB[i] = 0;
      else waitB[i] = waitB[i] + 1;
      if (waitB[i] > maxWaitB) maxWaitB = waitB[i];
    end
    @(posedge clk);
    modelStep(0, NA, MBA, int'(ra), int'(la), rst);
    modelStep(1, NB, MBB, int'(rb), int'(lb), rst);
    #1;
    tickNo++;
    $display("tick=%0d rst=%0b reqA=%b lastA=%b gntA=%b idA=%0d cntA=%0d reqB=%b lastB=%b gntB=%b idB=%0d cntB=%0d",
             tickNo, rst, ra, la, gntA, idA, cntA, rb, lb, gntB, idB, cntB);
    checkEq("gntA", int'(gntA), expGnt(0));
    checkEq("validA", int'(validA), int'(mValid[0]));
    checkEq("idA", int'(idA), mOwn[0]);
    checkEq("cntA", int'(cntA), mCnt[0]);
    checkEq("onehotA", int'($onehot0(gntA)), 1);
    checkEq("gntB", int'(gntB), expGnt(1));
    checkEq("validB", int'(validB), int'(mValid[1]));
    checkEq("idB", int'(idB), mOwn[1]);
    checkEq("cntB", int'(cntB), mCnt[1]);
    checkEq("onehotB", int'($onehot0(gntB)), 1);
  endtask

  initial begin
    reset = 1'b1; reqA = '0; lastA = '0; reqB = '0; lastB = '0;
    for (int i = 0; i < NA; i++) waitA[i] = 0;
    for (int i = 0; i < NB; i++) waitB[i] = 0;

    // Reset state
    tick(1, 2'b00, 2'b00, 3'b000, 3'b000);
    tick(1, 2'b00, 2'b00, 3'b000, 3'b000);
    checkEq("rstGntA", int'(gntA), 0);
    checkEq("rstCntA", int'(cntA), 0);
    checkEq("rstIdA", int'(idA), 0);
    checkEq("rstValidB", int'(validB), 0);

    // Single requester holds: 1..4 then re-granted; B rotates every cycle
    for (int i = 0; i < 5; i++) begin
      tick(0, 2'b01, 2'b00, 3'b111, 3'b000);
      checkEq("s1Gnt", int'(gntA), 1);
      checkEq("s1Cnt", int'(cntA), (i % 4) + 1);
      checkEq("bRotate", int'(gntB), 1 << (i % 3));
    end

    // Full contention: 01 x4, 10 x4, 01 x4
    tick(1, 2'b00, 2'b00, 3'b000, 3'b000);
    for (int i = 0; i < 12; i++) begin
      tick(0, 2'b11, 2'b00, 3'($urandom), 3'($urandom));
      checkEq("s2Gnt", int'(gntA), ((i / 4) % 2 == 0) ? 1 : 2);
    end

    // last[0] in owner 0's second granted cycle hands over immediately
    tick(1, 2'b00, 2'b00, 3'b000, 3'b000);
    tick(0, 2'b11, 2'b00, 3'b000, 3'b000);
    tick(0, 2'b11, 2'b00, 3'b000, 3'b000);
    checkEq("s3Cnt2", int'(cntA), 2);
    tick(0, 2'b11, 2'b01, 3'b000, 3'b000);
    checkEq("s3Gnt", int'(gntA), 2);
    checkEq("s3Cnt", int'(cntA), 1);

    // Owner 1 drops req in its third cycle, nobody else waiting
    tick(0, 2'b10, 2'b00, 3'b000, 3'b000);
    tick(0, 2'b10, 2'b00, 3'b000, 3'b000);
    checkEq("s4Cnt3", int'(cntA), 3);
    tick(0, 2'b00, 2'b00, 3'b000, 3'b000);
    checkEq("s4Gnt", int'(gntA), 0);
    checkEq("s4Valid", int'(validA), 0);
    checkEq("s4Id", int'(idA), 1);
    checkEq("s4Cnt", int'(cntA), 0);
    tick(0, 2'b11, 2'b00, 3'b000, 3'b000);
    checkEq("s4Regrant", int'(gntA), 1);

    // Reset mid-burst
    tick(1, 2'b00, 2'b00, 3'b000, 3'b000);
    tick(0, 2'b10, 2'b00, 3'b000, 3'b000);
    tick(0, 2'b10, 2'b00, 3'b000, 3'b000);
    checkEq("s5Cnt2", int'(cntA), 2);
    tick(1, 2'b10, 2'b00, 3'b111, 3'b000);
    checkEq("s5RstGnt", int'(gntA), 0);
    checkEq("s5RstCnt", int'(cntA), 0);
    tick(0, 2'b10, 2'b00, 3'b000, 3'b000);
    checkEq("s5Gnt", int'(gntA), 2);

    // last from a non-owner is ignored
    tick(1, 2'b00, 2'b00, 3'b000, 3'b000);
    tick(0, 2'b01, 2'b10, 3'b000, 3'b000);
    tick(0, 2'b11, 2'b10, 3'b000, 3'b000);
    checkEq("lastIgnGnt", int'(gntA), 1);
    checkEq("lastIgnCnt", int'(cntA), 2);

    // Sustained contention with sporadic last
    for (int i = 0; i < 60; i++) begin
      tick(0, 2'b11, ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
           3'b111, ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000);
    end

    // Fully random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 49) == 0), 2'($urandom),
           ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00,
           3'($urandom),
           ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000);
    end

    checkEq("fairA", int'(maxWaitA <= BOUND_A), 1);
    checkEq("fairB", int'(maxWaitB <= BOUND_B), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
